vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between two requesters:
  - display line prefetch, which fills the scanout line buffer during horizontal blanking;
  - CPU read/write accesses over a req/ack handshake.
- Line prefetch has priority. A fairness slot guarantees CPU progress during long fetches.
- Sits between the VGA timing/scanout logic and the framebuffer RAM.

Parameters:
- WIDTH, 256, visible pixels per line = words fetched per line
- HEIGHT, 192, visible lines; line_y >= HEIGHT requests are ignored
- ADDR_W, 16, RAM address width
- DATA_W, 12, RAM word width (one 4:4:4 RGB pixel per word)
- FB_BASE, 0, RAM address of pixel (0,0)
- CPU_SLOT_PERIOD, 8, consecutive fetch reads after which one pending CPU access is inserted

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse: fetch line line_y now
- line_y  in  16  line index, sampled with line_start
- lb_we  out  1  line-buffer write strobe
- lb_addr  out  16  line-buffer index (pixel x)
- lb_wdata  out  DATA_W  pixel data
- fetch_busy  out  1  prefetch in progress
- underrun  out  1  one-cycle pulse: line_start arrived while fetch_busy
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU RAM address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset: async on rst_n low. All outputs 0, FSM in IDLE, counters and pending flags cleared. Asserting reset mid-operation aborts everything immediately; no ack or lb_we is produced for in-flight accesses.
- FSM states: IDLE, FETCH, CPU_ACC, CPU_WAIT.
- IDLE
  - line_start with line_y < HEIGHT: latch y, set x = 0, go to FETCH.
  - Otherwise, if cpu_req: go to CPU_ACC.
  - line_start and cpu_req in the same cycle: fetch wins.
- FETCH
  - Each cycle: mem_en = 1, mem_we = 0, mem_addr = FB_BASE + y*WIDTH + x (truncated to ADDR_W). Then x++ and slot_cnt++.
  - One cycle later: lb_we = 1, lb_addr = that x, lb_wdata = mem_rdata.
  - When slot_cnt reaches CPU_SLOT_PERIOD and cpu_req is high: go to CPU_ACC, then resume FETCH at the next x; slot_cnt resets to 0.
  - After the read with x = WIDTH-1 is issued: go to IDLE (or CPU_ACC if cpu_req).
- CPU_ACC: mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata. Go to CPU_WAIT.
- CPU_WAIT
  - cpu_ack = 1. For reads, cpu_rdata = mem_rdata.
  - The trailing fetch lb_we from the previous FETCH cycle may coincide with this cycle; this is legal.
  - Return to FETCH if a fetch is suspended or pending, else IDLE.
  - cpu_req still high in the cycle after ack is treated as a new request.
- fetch_busy: high from the cycle after an accepted line_start through the cycle of the last lb_we (x = WIDTH-1). Duration is WIDTH + 1 cycles plus 2 per inserted CPU slot.
- line_start while fetch_busy:
  - underrun pulses for 1 cycle;
  - the current fetch is abandoned (no further lb_we for the old y, except the one already in flight);
  - the new fetch restarts at x = 0 with the new line_y.
- line_start during CPU_ACC/CPU_WAIT: latched as pending. The fetch starts the cycle after CPU_WAIT.
- line_start with line_y >= HEIGHT: ignored. No underrun and no abort of an active fetch.
- Invariant: at most one RAM access per cycle; mem_en never asserts for two requesters at once.

Decomposition:
- Package vga_pkg holds:
  - state enum arb_state_t;
  - pixel_t typedef (logic [11:0]);
  - default WIDTH/HEIGHT constants shared with the vga timing block.
- One sub-module, vram_fetch_addr_gen: holds y/x counters and base-address computation, keeping y*WIDTH out of the FSM. It uses a running base register incremented by WIDTH, not a multiplier.

Test Plan:
- Reset: rst_n low mid-fetch at x = 100 -> all outputs 0 in the same cycle. After release, no lb_we until the next line_start.
- Idle fetch: line_y = 2 -> mem_addr 512..767 on consecutive cycles; lb_addr 0..255 each one cycle later; fetch_busy high for 257 cycles; no CPU activity.
- CPU read idle: cpu_req, cpu_addr = 0x1234, RAM holds 0xABC -> mem_en at t+1, cpu_ack with cpu_rdata = 0xABC at t+2.
- CPU write during fetch: cpu_req held from x = 3 -> write issued right after the 8th fetch read (x = 7). The fetch resumes at x = 8, fetch_busy lasts 259 cycles, and a readback returns the written value.
- Underrun: second line_start (y = 5) at x = 50 -> underrun pulses once. lb_addr restarts at 0 with mem_addr = 1280.
- Blanking: line_start with line_y = 192 -> no mem_en, fetch_busy stays 0, no underrun.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default raster size, pixel type and the VRAM arbiter state encoding.
package vga_pkg;
    localparam int VGA_WIDTH  = 256;
    localparam int VGA_HEIGHT = 192;

    typedef logic [11:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_CPU_ACC  = 2'd2,
        ST_CPU_WAIT = 2'd3
    } arb_state_t;
endpackage

// File: rtl/vram_fetch_addr_gen.sv
// Line-prefetch address generator: pixel counter plus a per-line base address,
// so the arbiter FSM never sees a y*WIDTH product.
module vram_fetch_addr_gen #(
    parameter int WIDTH   = 256,
    parameter int ADDR_W  = 16,
    parameter int FB_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [15:0]       load_y,
    input  logic              step,
    output logic [15:0]       x,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [31:0] W_BITS = 32'(WIDTH);

    logic [15:0]       y_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] base_n;

    // Constant-coefficient shift-add; only used when lines are not requested in order.
    function automatic logic [ADDR_W-1:0] line_base(input logic [15:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++)
            if (W_BITS[i]) acc = acc + ADDR_W'(32'(y) << i);
        return acc;
    endfunction

    // Normal scanout asks for y+1 after y: advance the running base by one line.
    always_comb begin
        if (load_y == y_r + 16'd1) base_n = base_r + ADDR_W'(WIDTH);
        else                       base_n = line_base(load_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r    <= '0;
            base_r <= '0;
            x      <= '0;
        end else if (load) begin
            y_r    <= load_y;
            base_r <= base_n;
            x      <= '0;
        end else if (step) begin
            x <= x + 16'd1;
        end
    end

    assign addr = ADDR_W'(FB_BASE) + base_r + ADDR_W'(x);
    assign last = (x == 16'(WIDTH - 1));
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout line prefetch has priority, CPU req/ack accesses
// are served when idle or in a fairness slot every CPU_SLOT_PERIOD fetch reads.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int WIDTH           = VGA_WIDTH,
    parameter int HEIGHT          = VGA_HEIGHT,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 12,
    parameter int FB_BASE         = 0,
    parameter int CPU_SLOT_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [15:0]       line_y,
    output logic              lb_we,
    output logic [15:0]       lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_busy,
    output logic              underrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int SLOT_W = $clog2(CPU_SLOT_PERIOD + 1);

    arb_state_t        state, state_n;
    logic              fetch_pend, pend_n;
    logic [SLOT_W-1:0] slot_cnt, slot_n;
    logic              busy_r, lb_we_r, cpu_we_r;
    logic [15:0]       lb_addr_r, fx;
    logic [ADDR_W-1:0] faddr;
    logic              flast, accept, fetch_rd, slot_due;

    assign accept   = line_start && (line_y < 16'(HEIGHT));
    assign fetch_rd = (state == ST_FETCH);
    assign slot_due = (32'(slot_cnt) + 32'd1 >= 32'(CPU_SLOT_PERIOD));

    vram_fetch_addr_gen #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .FB_BASE(FB_BASE)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .load_y(line_y),
        .step  (fetch_rd && !accept),
        .x     (fx),
        .addr  (faddr),
        .last  (flast)
    );

    // A line_start in FETCH restarts the line; the read issued in that cycle is discarded.
    always_comb begin
        state_n = state;
        pend_n  = fetch_pend;
        slot_n  = slot_cnt;
        if (accept) slot_n = '0;
        case (state)
            ST_IDLE: begin
                if (accept)       state_n = ST_FETCH;
                else if (cpu_req) state_n = ST_CPU_ACC;
            end
            ST_FETCH: begin
                if (!accept) begin
                    if (flast) begin
                        state_n = cpu_req ? ST_CPU_ACC : ST_IDLE;
                        pend_n  = 1'b0;
                        slot_n  = '0;
                    end else if (slot_due && cpu_req) begin
                        state_n = ST_CPU_ACC;
                        pend_n  = 1'b1;
                        slot_n  = '0;
                    end else begin
                        slot_n = slot_due ? SLOT_W'(CPU_SLOT_PERIOD) : slot_cnt + SLOT_W'(1);
                    end
                end
            end
            ST_CPU_ACC: begin
                state_n = ST_CPU_WAIT;
                if (accept) pend_n = 1'b1;
            end
            default: begin
                state_n = (accept || fetch_pend) ? ST_FETCH : ST_IDLE;
                pend_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_pend <= 1'b0;
            slot_cnt   <= '0;
            busy_r     <= 1'b0;
            lb_we_r    <= 1'b0;
            lb_addr_r  <= '0;
            cpu_we_r   <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pend <= pend_n;
            slot_cnt   <= slot_n;
            lb_we_r    <= fetch_rd && !accept;
            if (fetch_rd) lb_addr_r <= fx;
            if (state == ST_CPU_ACC) cpu_we_r <= cpu_we;
            if (accept)
                busy_r <= 1'b1;
            else if (lb_we_r && lb_addr_r == 16'(WIDTH - 1))
                busy_r <= 1'b0;
        end
    end

    assign lb_we      = lb_we_r;
    assign lb_addr    = lb_addr_r;
    assign lb_wdata   = lb_we_r ? mem_rdata : '0;
    assign fetch_busy = busy_r;
    assign underrun   = accept && busy_r;

    assign cpu_ack    = (state == ST_CPU_WAIT);
    assign cpu_rdata  = (cpu_ack && !cpu_we_r) ? mem_rdata : '0;

    assign mem_en     = fetch_rd || (state == ST_CPU_ACC);
    assign mem_we     = (state == ST_CPU_ACC) && cpu_we;
    assign mem_addr   = fetch_rd ? faddr : (state == ST_CPU_ACC) ? cpu_addr : '0;
    assign mem_wdata  = mem_we ? cpu_wdata : '0;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural RAM, scoreboard queues for line-buffer
// writes and CPU completions, and immediate-assertion checks.
module tb_vram_arbiter;
    localparam int W = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [15:0] line_y;
    logic        lb_we;
    logic [15:0] lb_addr;
    logic [11:0] lb_wdata;
    logic        fetch_busy, underrun;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [11:0] cpu_wdata, cpu_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [11:0] mem_wdata, mem_rdata;

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .fetch_busy(fetch_busy), .underrun(underrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] x; logic [11:0] d; } lb_exp_t;
    typedef struct { logic we; logic [11:0] d; } cpu_exp_t;

    lb_exp_t     sb_lb[$];
    cpu_exp_t    sb_cpu[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          busy_cnt = 0, urun_cnt = 0, lb_cnt = 0, ack_cnt = 0, we_cnt = 0, en_cnt = 0;
    logic [11:0] wmem [int];

    function automatic logic [11:0] ram_init(input int a);
        if (a == 'h1234) return 12'hABC;
        return 12'(a * 37 + 5);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)]
                                                          : ram_init(int'(mem_addr));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        lb_exp_t  e;
        cpu_exp_t c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fetch_busy) busy_cnt++;
                if (underrun)   urun_cnt++;
                if (mem_en)     en_cnt++;
                if (mem_en && mem_we) we_cnt++;
                if (lb_we) begin
                    lb_cnt++;
                    if (sb_lb.size() == 0) chk("lb_unexpected", 32'(lb_we), 0);
                    else begin
                        e = sb_lb.pop_front();
                        chk("lb_addr", 32'(lb_addr), 32'(e.x));
                        chk("lb_wdata", 32'(lb_wdata), 32'(e.d));
                    end
                end
                if (cpu_ack) begin
                    ack_cnt++;
                    if (sb_cpu.size() == 0) chk("ack_unexpected", 32'(cpu_ack), 0);
                    else begin
                        c = sb_cpu.pop_front();
                        if (!c.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(c.d));
                    end
                end
            end
        end
    endtask

    task automatic push_line(input int y);
        lb_exp_t e;
        sb_lb.delete();
        for (int x = 0; x < W; x++) begin
            e.x = 16'(x);
            e.d = ram_init(y * W + x);
            sb_lb.push_back(e);
        end
    endtask

    task automatic start_line(input int y);
        busy_cnt   = 0;
        line_start = 1'b1;
        line_y     = 16'(y);
        @(posedge clk); #1;
        line_start = 1'b0;
        push_line(y);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (!(mem_en && !mem_we && mem_addr == 16'(a)) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_addr", 32'(mem_addr), 32'(a));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy && n < 600) begin @(posedge clk); #1; n++; end
        chk("busy_done", 32'(fetch_busy), 0);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!cpu_ack && n < 600) begin @(posedge clk); #1; n++; end
        chk("ack_seen", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
    endtask

    task automatic push_cpu(input logic we, input logic [11:0] d);
        cpu_exp_t c;
        c.we = we;
        c.d  = d;
        sb_cpu.push_back(c);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lb"},  32'({lb_we, lb_addr, lb_wdata}), 0);
        chk({tag, "_fb"},  32'({fetch_busy, underrun}), 0);
        chk({tag, "_cpu"}, 32'({cpu_ack, cpu_rdata}), 0);
        chk({tag, "_mem"}, 32'({mem_en, mem_we, mem_addr}), 0);
        chk({tag, "_wd"},  32'(mem_wdata), 0);
    endtask

    initial begin
        int prev, base0, lb0;
        rst_n = 1'b0; line_start = 1'b0; line_y = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fork monitor(); join_none
        #1;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain line fetch from idle, y = 2
        base0 = ack_cnt + we_cnt;
        start_line(2);
        for (int i = 0; i < W; i++) begin
            chk("fetch_addr", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'(512 + i)}));
            @(posedge clk); #1;
        end
        wait_idle();
        chk("fetch_busy_len", busy_cnt, 257);
        chk("fetch_no_cpu", ack_cnt + we_cnt - base0, 0);

        // CPU read while idle
        push_cpu(1'b0, 12'hABC);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        @(posedge clk); #1;
        chk("cpu_rd_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'h1234}));
        @(posedge clk); #1;
        chk("cpu_rd_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(posedge clk); #1;

        // CPU write in the fairness slot during a fetch of y = 3
        start_line(3);
        wait_addr(768 + 3);
        push_cpu(1'b1, 12'h000);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 12'h5A5;
        prev = int'(mem_addr);
        for (int n = 0; n < 50 && !(mem_en && mem_we); n++) begin
            prev = int'(mem_addr);
            @(posedge clk); #1;
        end
        chk("slot_after_x7", 32'(prev), 768 + 7);
        chk("slot_wr", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 16'h4000, 12'h5A5}));
        @(posedge clk); #1;
        chk("slot_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("slot_resume", 32'(mem_addr), 768 + 8);
        wait_idle();
        chk("slot_busy_len", busy_cnt, 259);
        push_cpu(1'b0, 12'h5A5);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        wait_ack();
        @(posedge clk); #1;

        // Fetch wins a tie with cpu_req; the read is then served in the slot
        push_cpu(1'b0, ram_init(16));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        start_line(4);
        chk("tie_fetch_wins", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'd1024}));
        wait_ack();
        wait_idle();
        chk("tie_busy_len", busy_cnt, 259);

        // Underrun: new line 5 arrives at x = 50 of line 2
        start_line(2);
        wait_addr(512 + 50);
        urun_cnt   = 0;
        line_start = 1'b1; line_y = 16'd5;
        #1 chk("urun_pulse", 32'(underrun), 1);
        @(posedge clk); #1;
        line_start = 1'b0;
        push_line(5);
        chk("urun_restart", 32'(mem_addr), 1280);
        wait_idle();
        chk("urun_count", urun_cnt, 1);

        // Blanking line while idle
        lb0 = en_cnt; busy_cnt = 0; urun_cnt = 0;
        line_start = 1'b1; line_y = 16'd192;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("blank_mem_en", en_cnt - lb0, 0);
        chk("blank_busy", busy_cnt, 0);
        chk("blank_urun", urun_cnt, 0);

        // Blanking line during the last visible line does not abort it
        start_line(191);
        urun_cnt = 0;
        wait_addr(191 * W + 20);
        line_start = 1'b1; line_y = 16'd200;
        #1 chk("blank_no_urun", 32'(underrun), 0);
        @(posedge clk); #1;
        line_start = 1'b0;
        chk("blank_no_abort", 32'(mem_addr), 191 * W + 21);
        wait_idle();
        chk("blank_busy_len", busy_cnt, 257);
        chk("blank_urun_cnt", urun_cnt, 0);

        // Reset mid-fetch at x = 100
        start_line(1);
        wait_addr(W + 100);
        rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        sb_lb.delete();
        lb0 = lb_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_lb", lb_cnt - lb0, 0);
        start_line(1);
        wait_idle();
        chk("rst_recover_len", busy_cnt, 257);

        @(posedge clk); #1;
        chk("sb_lb_empty", sb_lb.size(), 0);
        chk("sb_cpu_empty", sb_cpu.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
